// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op and state encodings,
// divider iteration count and small sign helpers.
package cpu_defs;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_MUL   = 4'd3,
    MD_MADD  = 4'd4,
    MD_MADDU = 4'd5,
    MD_MSUB  = 4'd6,
    MD_MSUBU = 4'd7,
    MD_DIV   = 4'd8,
    MD_DIVU  = 4'd9,
    MD_MTHI  = 4'd10,
    MD_MTLO  = 4'd11
  } md_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_WB
  } mdu_state_t;

  localparam int unsigned MDU_DIV_CYCLES = 32;

  function automatic logic is_mul_op(input md_op_t op);
    return op inside {MD_MULT, MD_MULTU, MD_MUL, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
  endfunction

  function automatic logic mul_signed(input md_op_t op);
    return op inside {MD_MULT, MD_MUL, MD_MADD, MD_MSUB};
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Magnitude of v when treated as signed, raw value otherwise.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? neg32(v) : v;
  endfunction

endpackage

// File: rtl/mdu_ctrl_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// start loads operands; kill abandons the current divide.
module mdu_divider
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        kill,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic [4:0]  cnt;
  logic [31:0] div_q;
  logic [32:0] partial;
  logic [32:0] diff;

  // quot doubles as the dividend shift register; its MSB feeds the partial remainder.
  assign partial = {rem, quot[31]};
  assign diff    = partial - {1'b0, div_q};
  assign done    = busy && (cnt == 5'(MDU_DIV_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy  <= 1'b0;
      cnt   <= '0;
      quot  <= '0;
      rem   <= '0;
      div_q <= '0;
    end else if (kill) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      quot  <= a;
      rem   <= '0;
      div_q <= b;
    end else if (busy) begin
      if (diff[32]) begin
        rem  <= partial[31:0];
        quot <= {quot[30:0], 1'b0};
      end else begin
        rem  <= diff[31:0];
        quot <= {quot[30:0], 1'b1};
      end
      cnt <= cnt + 5'd1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide sequencer: pipelined multiplier, iterative divider, HI/LO owner.
// Optional MDU_DIV_EARLY_EN: divides with |a| < |b| (b != 0) bypass the iterations.
module mdu_ctrl
  import cpu_defs::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_result,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  mdu_state_t  state, state_nxt;
  md_op_t      req_op_t, op_q;
  logic [31:0] a_q, b_q, hi_q, lo_q, fix_hi, fix_lo;
  logic [2:0]  mul_cnt;
  logic [63:0] pipe [MUL_LAT];
  logic [63:0] ext_a, ext_b, prod_now, prod;
  logic        hs, is_div_req, early_hit, early_q;
  logic [31:0] req_a_mag, req_b_mag, a_mag_q;
  logic        div_start, div_busy, div_done;
  logic [31:0] div_quot, div_rem, quot_u, rem_u, quot_s, rem_s;
  logic        div_signed_q;

  assign req_op_t   = md_op_t'(req_op);
  assign hs         = req_valid && (state == ST_IDLE) && !flush;
  assign is_div_req = (req_op_t == MD_DIV) || (req_op_t == MD_DIVU);
  assign req_a_mag  = mag32(req_a, req_op_t == MD_DIV);
  assign req_b_mag  = mag32(req_b, req_op_t == MD_DIV);

`ifdef MDU_DIV_EARLY_EN
  assign early_hit = (req_b_mag != '0) && (req_a_mag < req_b_mag);
`else
  assign early_hit = 1'b0;
`endif

  assign div_start = hs && is_div_req && !early_hit;

  mdu_divider u_div (
    .clk    (clk),
    .resetn (resetn),
    .start  (div_start),
    .kill   (flush),
    .a      (req_a_mag),
    .b      (req_b_mag),
    .busy   (div_busy),
    .done   (div_done),
    .quot   (div_quot),
    .rem    (div_rem)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (hs) begin
          if (is_mul_op(req_op_t)) state_nxt = ST_MUL;
          else if (is_div_req)     state_nxt = early_hit ? ST_FIX : ST_DIV;
        end
      end
      ST_MUL:  if (mul_cnt == 3'(MUL_LAT - 1)) state_nxt = ST_WB;
      ST_DIV:  if (div_done || !div_busy) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_WB;
      ST_WB:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_comb begin
    req_ready   = (state == ST_IDLE);
    resp_valid  = (state == ST_WB) && !flush;
    resp_result = '0;
    if (resp_valid && op_q == MD_MUL) resp_result = prod[31:0];
  end

  // Operands are sign/zero-extended to 64 bits so one truncated multiply serves both signednesses.
  assign ext_a    = mul_signed(op_q) ? {{32{a_q[31]}}, a_q} : {32'h0, a_q};
  assign ext_b    = mul_signed(op_q) ? {{32{b_q[31]}}, b_q} : {32'h0, b_q};
  assign prod_now = ext_a * ext_b;
  assign prod     = pipe[MUL_LAT-1];

  always_ff @(posedge clk) begin
    pipe[0] <= prod_now;
    for (int unsigned i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign div_signed_q = (op_q == MD_DIV);
  assign a_mag_q      = mag32(a_q, div_signed_q);
  assign quot_u       = early_q ? '0 : div_quot;
  assign rem_u        = early_q ? a_mag_q : div_rem;
  assign quot_s       = (div_signed_q && (a_q[31] ^ b_q[31])) ? neg32(quot_u) : quot_u;
  assign rem_s        = (div_signed_q && a_q[31]) ? neg32(rem_u) : rem_u;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= MD_NONE;
      mul_cnt <= '0;
      fix_hi  <= '0;
      fix_lo  <= '0;
      early_q <= 1'b0;
    end else begin
      if (hs) begin
        op_q    <= req_op_t;
        a_q     <= req_a;
        b_q     <= req_b;
        mul_cnt <= '0;
        early_q <= early_hit;
        if (req_op_t == MD_MTHI) hi_q <= req_a;
        if (req_op_t == MD_MTLO) lo_q <= req_a;
      end
      if (state == ST_MUL) mul_cnt <= mul_cnt + 3'd1;
      if (state == ST_FIX) begin
        fix_hi <= rem_s;
        fix_lo <= quot_s;
      end
      if (state == ST_WB && !flush) begin
        case (op_q)
          MD_MULT, MD_MULTU: {hi_q, lo_q} <= prod;
          MD_MADD, MD_MADDU: {hi_q, lo_q} <= {hi_q, lo_q} + prod;
          MD_MSUB, MD_MSUBU: {hi_q, lo_q} <= {hi_q, lo_q} - prod;
          MD_DIV, MD_DIVU: begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
          end
          default: ;
        endcase
      end
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: arithmetic reference model plus directed vectors.
module tb_mdu_ctrl;
  import cpu_defs::*;

  localparam int unsigned L = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_a = '0, req_b = '0;
  logic        req_ready, resp_valid;
  logic [31:0] resp_result, hi_o, lo_o;

  int errors = 0;
  int checks = 0;

  mdu_ctrl #(.MUL_LAT(L)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .flush       (flush),
    .resp_valid  (resp_valid),
    .resp_result (resp_result),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  bit          chk_en = 0;
  bit          m_busy = 0, m_upd = 0, m_dz = 0, unk_hi = 0, unk_lo = 0;
  int          m_done = 0;
  logic [31:0] m_hi = '0, m_lo = '0, m_nhi = '0, m_nlo = '0, m_res = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural result and latency of one op, from plain arithmetic.
  task automatic predict(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] nhi, output logic [31:0] nlo,
                         output logic [31:0] res, output int lat, output bit dz);
    md_op_t      o;
    int          sa, sb;
    logic [63:0] p64, acc;
    logic [31:0] ma, mb;
    o = md_op_t'(op);
    sa = a;
    sb = b;
    nhi = m_hi;
    nlo = m_lo;
    res = '0;
    lat = 0;
    dz = 0;
    acc = {m_hi, m_lo};
    if (o inside {MD_MULT, MD_MUL, MD_MADD, MD_MSUB}) p64 = 64'(longint'(sa) * longint'(sb));
    else p64 = {32'h0, a} * {32'h0, b};
    ma = (o == MD_DIV && a[31]) ? -a : a;
    mb = (o == MD_DIV && b[31]) ? -b : b;
    case (o)
      MD_MULT, MD_MULTU: begin {nhi, nlo} = p64; lat = L + 1; end
      MD_MUL:            begin res = p64[31:0]; lat = L + 1; end
      MD_MADD, MD_MADDU: begin {nhi, nlo} = acc + p64; lat = L + 1; end
      MD_MSUB, MD_MSUBU: begin {nhi, nlo} = acc - p64; lat = L + 1; end
      MD_DIVU, MD_DIV: begin
        lat = 34;
        if (b == 0) dz = 1;
        else if (o == MD_DIVU) begin nlo = a / b; nhi = a % b; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin nlo = 32'h8000_0000; nhi = 0; end
        else begin nlo = sa / sb; nhi = sa % sb; end
`ifdef MDU_DIV_EARLY_EN
        if (b != 0 && ma < mb) lat = 2;
`endif
      end
      default: lat = 0;
    endcase
  endtask

  always @(posedge clk) begin
    int lat;
    bit dz;
    if (!resetn) begin
      m_busy = 0; m_hi = '0; m_lo = '0; unk_hi = 0; unk_lo = 0;
    end else if (m_busy) begin
      if (flush) m_busy = 0;
      else if (cyc == m_done) begin
        if (m_upd) begin
          if (m_dz) begin unk_hi = 1; unk_lo = 1; end
          else begin m_hi = m_nhi; m_lo = m_nlo; end
        end
        m_busy = 0;
      end
    end else if (req_valid && !flush) begin
      if (req_op == MD_MTHI) begin m_hi = req_a; unk_hi = 0; end
      else if (req_op == MD_MTLO) begin m_lo = req_a; unk_lo = 0; end
      else begin
        predict(req_op, req_a, req_b, m_nhi, m_nlo, m_res, lat, dz);
        if (lat > 0) begin
          m_busy = 1;
          m_done = cyc + lat;
          m_upd = (req_op != MD_MUL);
          m_dz = dz;
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    bit ev;
    if (chk_en) begin
      ev = m_busy && (cyc == m_done) && !flush;
      chk("req_ready", 32'(req_ready), 32'(!m_busy));
      chk("resp_valid", 32'(resp_valid), 32'(ev));
      chk("resp_result", resp_result, ev ? m_res : 32'h0);
      if (!unk_hi) chk("hi_o", hi_o, m_hi);
      if (!unk_lo) chk("lo_o", lo_o, m_lo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    tick();
    req_valid = 1'b0;
    req_op = MD_NONE;
  endtask

  task automatic wait_resp(input string name, input int exp_lat);
    int n;
    n = 0;
    while (n < 100) begin
      n++;
      @(negedge clk);
      if (resp_valid === 1'b1) break;
    end
    chk(name, n, exp_lat);
    tick();
  endtask

  initial begin
    int n;
    resetn = 1'b0;
    tick();
    chk_en = 1;
    tick();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_result", resp_result, 32'h0);
    chk("rst_hi", hi_o, 32'h0);
    chk("rst_lo", lo_o, 32'h0);
    resetn = 1'b1;
    tick();

    send(MD_MULT, 32'hFFFF_FFFF, 32'd2);
    wait_resp("mult_lat", L + 1);
    chk("mult_hi", hi_o, 32'hFFFF_FFFF);
    chk("mult_lo", lo_o, 32'hFFFF_FFFE);

    send(MD_DIVU, 32'd100, 32'd7);
    wait_resp("divu_lat", 34);
    chk("divu_lo", lo_o, 32'd14);
    chk("divu_hi", hi_o, 32'd2);
    send(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_resp("div_lat", 34);
    chk("div_lo", lo_o, 32'hFFFF_FFFD);
    chk("div_hi", hi_o, 32'hFFFF_FFFF);
    send(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_resp("divovf_lat", 34);
    chk("divovf_lo", lo_o, 32'h8000_0000);
    chk("divovf_hi", hi_o, 32'h0);

    send(MD_MTHI, 32'h0, 32'h0);
    send(MD_MTLO, 32'hFFFF_FFFF, 32'h0);
    chk("mtlo_lo", lo_o, 32'hFFFF_FFFF);
    send(MD_MADDU, 32'd1, 32'd1);
    wait_resp("maddu_lat", L + 1);
    chk("maddu_hi", hi_o, 32'd1);
    chk("maddu_lo", lo_o, 32'd0);
    send(MD_MSUB, 32'd1, 32'd1);
    wait_resp("msub_lat", L + 1);
    chk("msub_hi", hi_o, 32'd0);
    chk("msub_lo", lo_o, 32'hFFFF_FFFF);

    send(MD_DIVU, 32'd100, 32'd7);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ready", 32'(req_ready), 32'd1);
    chk("flush_hi", hi_o, 32'd0);
    chk("flush_lo", lo_o, 32'hFFFF_FFFF);
    send(MD_MULT, 32'd3, 32'd5);
    wait_resp("post_flush_lat", L + 1);
    chk("post_flush_lo", lo_o, 32'd15);

    send(MD_MUL, 32'd2, 32'd3);
    repeat (L) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("wbflush_lo", lo_o, 32'd15);
    flush = 1'b1;
    send(MD_MTHI, 32'h1234, 32'h0);
    flush = 1'b0;
    chk("mthi_flush_hi", hi_o, 32'd0);

    send(MD_MTHI, 32'hA, 32'h0);
    send(MD_MTLO, 32'hB, 32'h0);
    req_valid = 1'b1;
    req_op = MD_MUL;
    req_a = 32'd6;
    req_b = 32'd7;
    tick();
    n = 0;
    while (n < 100) begin
      n++;
      @(negedge clk);
      if (resp_valid === 1'b1) break;
    end
    chk("mul_hold_lat", n, L + 1);
    chk("mul_result", resp_result, 32'd42);
    req_valid = 1'b0;
    req_op = MD_NONE;
    tick();
    tick();
    chk("mul_once_ready", 32'(req_ready), 32'd1);
    chk("mul_hi", hi_o, 32'hA);
    chk("mul_lo", lo_o, 32'hB);

`ifdef MDU_DIV_EARLY_EN
    send(MD_DIVU, 32'd3, 32'd10);
    wait_resp("divu_small_lat", 2);
`else
    send(MD_DIVU, 32'd3, 32'd10);
    wait_resp("divu_small_lat", 34);
`endif
    chk("divu_small_lo", lo_o, 32'd0);
    chk("divu_small_hi", hi_o, 32'd3);

    send(MD_DIVU, 32'd5, 32'd0);
    wait_resp("div0_lat", 34);

    send(MD_DIV, 32'd1000, 32'd3);
    repeat (5) tick();
    resetn = 1'b0;
    tick();
    tick();
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_hi", hi_o, 32'd0);
    chk("rst_mid_lo", lo_o, 32'd0);
    resetn = 1'b1;
    tick();

    send(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_resp("multu_lat", L + 1);
    chk("multu_hi", hi_o, 32'hFFFF_FFFE);
    chk("multu_lo", lo_o, 32'd1);
    send(MD_MTHI, 32'h0, 32'h0);
    send(MD_MTLO, 32'd100, 32'h0);
    send(MD_MADD, 32'hFFFF_FFFD, 32'd5);
    wait_resp("madd_lat", L + 1);
    chk("madd_hi", hi_o, 32'd0);
    chk("madd_lo", lo_o, 32'd85);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
